// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one external combinational ALU
// between two requesters. IDLE accepts, EXEC drives the ALU, RESP holds the result.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_res,
  output logic             resp_zero,
  output logic             resp_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant0, grant1, acc;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic             id_q;

  // On a tie the requester not granted last wins.
  assign grant0 = req_valid0 & (~req_valid1 | last_grant);
  assign grant1 = req_valid1 & (~req_valid0 | ~last_grant);
  assign acc    = (state == IDLE) & (grant0 | grant1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is gated by rst so it reads 0 while reset is held, not just after it.
  always_comb begin
    req_ready0 = (state == IDLE) & grant0 & ~rst;
    req_ready1 = (state == IDLE) & grant1 & ~rst;
    resp_valid = (state == RESP);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      resp_res   <= '0;
      resp_zero  <= 1'b0;
      resp_id    <= 1'b0;
    end else begin
      if (acc) begin
        a_q        <= grant1 ? req_a1  : req_a0;
        b_q        <= grant1 ? req_b1  : req_b0;
        op_q       <= grant1 ? req_op1 : req_op0;
        id_q       <= grant1;
        last_grant <= grant1;
      end
      if (state == EXEC) begin
        resp_res  <= alu_res;
        resp_zero <= alu_zero;
        resp_id   <= id_q;
      end
    end
  end

  // ALU is fed only from the operand registers so it holds steady outside EXEC.
  assign alu_A  = a_q;
  assign alu_B  = b_q;
  assign alu_op = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, scoreboard of expected
// responses filled on accept and drained on response handshake.
module tb_alu_arbiter;

  logic        clk, rst;
  logic        req_valid0, req_valid1, req_ready0, req_ready1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [2:0]  req_op0, req_op1;
  logic [31:0] alu_A, alu_B, alu_res;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        resp_valid, resp_ready, resp_zero, resp_id, busy;
  logic [31:0] resp_res;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_res(resp_res), .resp_zero(resp_zero), .resp_id(resp_id),
    .busy(busy)
  );

  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return {31'b0, $signed(a) < $signed(b)};
      default: return a ^ b;
    endcase
  endfunction

  assign alu_res  = alu_f(alu_A, alu_B, alu_op);
  assign alu_zero = (alu_res == 32'h0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {logic id; logic zero; logic [31:0] res;} exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int   acc_edge[$], hs_edge[$];
  bit   acc_id[$], hs_id[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge; events it sees complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_onehot", {63'b0, req_ready0 & req_ready1}, 64'd0);
      if (req_valid0 && req_ready0) begin
        sb.push_back({1'b0, alu_f(req_a0, req_b0, req_op0) == 32'h0, alu_f(req_a0, req_b0, req_op0)});
        acc_edge.push_back(cyc + 1); acc_id.push_back(1'b0);
      end
      if (req_valid1 && req_ready1) begin
        sb.push_back({1'b1, alu_f(req_a1, req_b1, req_op1) == 32'h0, alu_f(req_a1, req_b1, req_op1)});
        acc_edge.push_back(cyc + 1); acc_id.push_back(1'b1);
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_resp", 64'd1, 64'd0);
        else begin
          e_mon = sb.pop_front();
          chk("sb_id",   {63'b0, resp_id},   {63'b0, e_mon.id});
          chk("sb_res",  {32'b0, resp_res},  {32'b0, e_mon.res});
          chk("sb_zero", {63'b0, resp_zero}, {63'b0, e_mon.zero});
        end
        hs_edge.push_back(cyc + 1); hs_id.push_back(resp_id);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    acc_edge.delete(); acc_id.delete(); hs_edge.delete(); hs_id.delete();
  endtask

  task automatic wait_ready(int idx);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((idx == 0) ? req_ready0 : req_ready1) return;
      n++;
      if (n > 50) begin chk("ready_timeout", 64'd0, 64'd1); return; end
    end
  endtask

  // Returns one ns after the accept edge, i.e. inside the EXEC cycle.
  task automatic send(int idx, logic [31:0] a, logic [31:0] b, logic [2:0] op);
    if (idx == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; req_valid0 = 1'b1; end
    else          begin req_a1 = a; req_b1 = b; req_op1 = op; req_valid1 = 1'b1; end
    wait_ready(idx);
    step();
    if (idx == 0) req_valid0 = 1'b0; else req_valid1 = 1'b0;
  endtask

  task automatic wait_acc(int n);
    int k = 0;
    while (acc_edge.size() < n) begin
      step(); k++;
      if (k > 100) begin chk("acc_timeout", 64'd0, 64'd1); break; end
    end
  endtask

  task automatic wait_hs(int n);
    int k = 0;
    while (hs_edge.size() < n) begin
      step(); k++;
      if (k > 100) begin chk("hs_timeout", 64'd0, 64'd1); break; end
    end
  endtask

  initial begin
    rst = 1'b1; resp_ready = 1'b0;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    req_a0 = 32'h1; req_b0 = 32'h2; req_op0 = 3'b010;
    req_a1 = 32'h3; req_b1 = 32'h4; req_op1 = 3'b010;
    #3;
    chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_busy",       {63'b0, busy},       64'd0);
    chk("rst_ready0",     {63'b0, req_ready0}, 64'd0);
    chk("rst_ready1",     {63'b0, req_ready1}, 64'd0);
    chk("rst_alu_A",      {32'b0, alu_A},      64'd0);
    chk("rst_alu_op",     {61'b0, alu_op},     64'd0);
    chk("rst_resp_res",   {32'b0, resp_res},   64'd0);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Single ADD with latency checks
    resp_ready = 1'b1;
    send(0, 32'hA5A5A5A5, 32'h5A5A5A5A, 3'b010);
    chk("add_exec_busy",   {63'b0, busy},       64'd1);
    chk("add_exec_rvalid", {63'b0, resp_valid}, 64'd0);
    chk("add_exec_alu_op", {61'b0, alu_op},     64'd2);
    chk("add_exec_alu_A",  {32'b0, alu_A},      64'hA5A5A5A5);
    step();
    chk("add_rvalid", {63'b0, resp_valid}, 64'd1);
    chk("add_res",    {32'b0, resp_res},   64'hFFFFFFFF);
    chk("add_zero",   {63'b0, resp_zero},  64'd0);
    chk("add_id",     {63'b0, resp_id},    64'd0);
    step();
    chk("add_idle_busy", {63'b0, busy}, 64'd0);

    // Zero flag from requester 1
    send(1, 32'h01234567, 32'h01234567, 3'b110);
    step();
    chk("zero_res",  {32'b0, resp_res},  64'd0);
    chk("zero_flag", {63'b0, resp_zero}, 64'd1);
    chk("zero_id",   {63'b0, resp_id},   64'd1);
    step();

    // Round-robin with both requesters held valid
    clear_logs();
    req_a0 = 32'd100; req_b0 = 32'd23; req_op0 = 3'b010;
    req_a1 = 32'hFFFFFFFF; req_b1 = 32'd1; req_op1 = 3'b010;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    wait_acc(4);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    wait_hs(4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_id%0d", i), {63'b0, (i < hs_id.size()) ? hs_id[i] : 1'bx}, {63'b0, i[0]});
    for (int i = 0; i < 3; i++)
      if (acc_edge.size() > i + 1 && hs_edge.size() > i)
        chk($sformatf("rr_gap%0d", i), acc_edge[i+1], hs_edge[i] + 1);
      else chk($sformatf("rr_gap%0d_missing", i), 64'd0, 64'd1);

    // Back-pressure: RESP held for 10 cycles with a competing request pending
    clear_logs();
    resp_ready = 1'b0;
    send(0, 32'h0F0F0000, 32'h00000F0F, 3'b001);
    step();
    req_a1 = 32'hDEADBEEF; req_b1 = 32'hDEADBEEF; req_op1 = 3'b000; req_valid1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rvalid", {63'b0, resp_valid}, 64'd1);
      chk("bp_res",    {32'b0, resp_res},   64'h0F0F0F0F);
      chk("bp_id",     {63'b0, resp_id},    64'd0);
      chk("bp_zero",   {63'b0, resp_zero},  64'd0);
      chk("bp_ready0", {63'b0, req_ready0}, 64'd0);
      chk("bp_ready1", {63'b0, req_ready1}, 64'd0);
    end
    resp_ready = 1'b1;
    wait_ready(1);
    step();
    req_valid1 = 1'b0;
    wait_hs(2);
    chk("bp_acc_count", acc_edge.size(), 64'd2);
    if (acc_edge.size() >= 2) chk("bp_acc_gap", acc_edge[1], hs_edge[0] + 1);

    // Late arrival of requester 1 during EXEC of requester 0
    clear_logs();
    send(0, 32'h11111111, 32'h22222222, 3'b010);
    req_a1 = 32'h76543210; req_b1 = 32'h0000ABCD; req_op1 = 3'b111; req_valid1 = 1'b1;
    @(negedge clk);
    chk("late_ready1_exec", {63'b0, req_ready1}, 64'd0);
    step();
    @(negedge clk);
    chk("late_ready1_resp", {63'b0, req_ready1}, 64'd0);
    wait_ready(1);
    step();
    req_valid1 = 1'b0;
    chk("late_alu_A",  {32'b0, alu_A},  64'h76543210);
    chk("late_alu_B",  {32'b0, alu_B},  64'h0000ABCD);
    chk("late_alu_op", {61'b0, alu_op}, 64'd7);
    wait_hs(2);
    if (acc_edge.size() >= 2) begin
      chk("late_acc_id",  {63'b0, acc_id[1]}, 64'd1);
      chk("late_acc_gap", acc_edge[1], hs_edge[0] + 1);
    end else chk("late_acc_missing", 64'd0, 64'd1);

    // Reset mid-RESP discards the transaction and restores the tie-break
    resp_ready = 1'b0;
    send(0, 32'h5, 32'h3, 3'b110);
    step();
    @(negedge clk);
    chk("mid_rvalid_before", {63'b0, resp_valid}, 64'd1);
    #2;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", {63'b0, resp_valid}, 64'd0);
    chk("mid_rst_busy",   {63'b0, busy},       64'd0);
    chk("mid_rst_ready0", {63'b0, req_ready0}, 64'd0);
    chk("mid_rst_ready1", {63'b0, req_ready1}, 64'd0);
    chk("mid_rst_res",    {32'b0, resp_res},   64'd0);
    chk("mid_rst_alu_A",  {32'b0, alu_A},      64'd0);
    sb.delete();
    clear_logs();
    step(); step();
    rst = 1'b0;
    resp_ready = 1'b1;
    wait_acc(1);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    if (acc_id.size() >= 1) chk("post_rst_tie_id", {63'b0, acc_id[0]}, 64'd0);
    wait_hs(1);
    repeat (4) step();
    chk("final_hs_count", hs_edge.size(), 64'd1);
    chk("final_sb_empty", sb.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 32-bit combinational ALU between two requesters. Each requester submits operands and a 3-bit operation code over a valid/ready handshake. The block latches the winning request, drives the shared ALU for one execute cycle, captures `res`/`zero`, and returns them with the requester ID on a single response channel. It sits between the ALU and its clients, such as the datapath controller and a debug/test port. The ALU itself is instantiated outside this block.

## Interface
- `WIDTH`, 32, operand/result width
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `req_valid0`, `req_valid1` in 1: request present, requester 0/1
- `req_ready0`, `req_ready1` out 1: request accepted this cycle
- `req_a0`, `req_a1` in WIDTH: operand A, requester 0/1
- `req_b0`, `req_b1` in WIDTH: operand B, requester 0/1
- `req_op0`, `req_op1` in 3: ALU operation code, passed through unmodified
- `alu_A`, `alu_B` out WIDTH: operands to the shared ALU
- `alu_op` out 3: operation to the shared ALU
- `alu_res` in WIDTH: ALU result
- `alu_zero` in 1: ALU zero flag
- `resp_valid` out 1: response present
- `resp_ready` in 1: consumer accepts response
- `resp_res` out WIDTH: captured result
- `resp_zero` out 1: captured zero flag
- `resp_id` out 1: requester that owns the response
- `busy` out 1: state is not IDLE

## Operation
- **States:** IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - Grant goes to the single valid requester.
  - If both requesters are valid, grant goes to the one not granted last. This is tracked in `last_grant`, which resets to 1 so requester 0 wins the first tie.
  - `req_readyN` = (state==IDLE) & grantN. This is combinational and at most one is high.
  - On valid&ready: latch a, b, op, and id into operand registers; update `last_grant`; go to EXEC.
  - With no valid request, stay in IDLE.
- **EXEC:** one cycle. At the clock edge, capture `alu_res`→`resp_res`, `alu_zero`→`resp_zero`, latched id→`resp_id`. Then go to RESP.
- **RESP**
  - `resp_valid`=1. All response fields stay stable until resp_valid&resp_ready.
  - On handshake, go to IDLE.
  - `req_ready*` stays 0 in EXEC and RESP. Requests arriving then wait.
- **ALU drive:** `alu_A`/`alu_B`/`alu_op` always come from the operand registers. They hold their last value outside EXEC and are never driven combinationally from `req_*`.
- **Requester rule:** once `req_validN` is asserted, it and its payload must stay stable until `req_readyN`. The block does not check this.
- **Width rule:** no arithmetic inside the block. Values pass through bit-exact.

## Timing
- **Reset (async, immediate):** all outputs 0, including `resp_valid`, `req_ready*`, `busy`, `alu_*`, and `resp_*`. `last_grant`=1. An in-flight transaction is discarded, and no response is issued for it after reset releases.
- **Latency:** accept at edge T; EXEC during cycle T+1; `resp_valid` high from T+2.
- **Back-to-back:** after a response handshake at edge R, the earliest next accept is at edge R+1 (from IDLE). Peak throughput is one operation per 3 cycles with `resp_ready` tied high.
- **Back-pressure:** `resp_ready` low holds RESP indefinitely. Fields must not change while held.
- **Simultaneous events**
  - Both requesters valid on consecutive transactions: grants alternate 0,1,0,1.
  - A requester deasserting valid never happens while it is granted (protocol rule).
- **`busy`:** high from the cycle after acceptance through the cycle of the response handshake.

## Test plan
- **Reset:** assert `rst` mid-RESP with `resp_valid`=1. Required: `resp_valid` and `busy` drop to 0 without a clock edge. After release, requester 0 wins the first tie.
- **Single ADD:** requester 0 sends A=32'hA5A5A5A5, B=32'h5A5A5A5A, op=3'b010 (ALU computes ADD), `resp_ready`=1. Required: accept at T; `alu_op`=010 during T+1; at T+2 `resp_res`=32'hFFFFFFFF, `resp_zero`=0, `resp_id`=0.
- **Zero flag:** requester 1 sends A=B=32'h01234567, op=3'b110 (SUB). Required: `resp_res`=0, `resp_zero`=1, `resp_id`=1.
- **Round-robin:** both requesters are held valid for 4 transactions. Required: `resp_id` sequence 0,1,0,1; each accept follows the previous handshake by exactly one cycle.
- **Back-pressure:** `resp_ready`=0 for 10 cycles in RESP. Required: `resp_*` stable; both `req_ready*`=0; the single accept occurs only after handshake plus one cycle.
- **Late arrival:** `req_valid1` rises during EXEC of a requester-0 transaction. Required: not accepted until IDLE; then granted, with operands returned bit-exact (A=32'h76543210, op=3'b111 passed through on `alu_op`).
